// File: rtl/node_port_adapter.sv
// node_port_adapter: node-side endpoint of the router core's node interface.
// Outbound packets are queued and offered to the core with an ack timeout,
// back-off and bounded retry. Inbound beats are queued first-word-fall-through.
//
// Handshake semantics (all interfaces): a transfer happens on a rising edge
// where valid and ready are both high. Valid never depends combinationally on
// ready. Host_Tx_Ready, Host_Rx_Valid and Packet_From_Node_Valid come straight
// from registers. The core side has no backpressure inbound, and outbound the
// core "ready" is Core_Load_Ack, which counts only while Packet_From_Node_Valid
// is high.
module node_port_adapter #(
  parameter int TX_DEPTH       = 4,
  parameter int RX_DEPTH       = 4,
  parameter int ACK_TIMEOUT    = 64,
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 8
) (
  input  logic        Clk_R,
  input  logic        Rst,
  input  logic [3:0]  Host_Tx_Addr,
  input  logic        Host_Tx_Flag,
  input  logic [23:0] Host_Tx_Data,
  input  logic        Host_Tx_Valid,
  output logic        Host_Tx_Ready,
  output logic [28:0] Packet_From_Node,
  output logic        Packet_From_Node_Valid,
  input  logic        Core_Load_Ack,
  input  logic [23:0] Packet_To_Node,
  input  logic        Packet_To_Node_Valid,
  output logic [23:0] Host_Rx_Data,
  output logic        Host_Rx_Valid,
  input  logic        Host_Rx_Ready,
  output logic        Tx_Drop,
  output logic [7:0]  Tx_Fail_Count,
  output logic        Rx_Overflow,
  output logic [1:0]  dbg_state
);

  localparam int TAW  = $clog2(TX_DEPTH);
  localparam int RAW  = $clog2(RX_DEPTH);
  localparam int TMAX = (ACK_TIMEOUT > BACKOFF_CYCLES) ? ACK_TIMEOUT : BACKOFF_CYCLES;
  // Timer only needs to reach TMAX-1; TMAX >= 2 keeps TW >= 1.
  localparam int TW   = $clog2(TMAX);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0]  ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0]  BO_LAST   = TW'(BACKOFF_CYCLES - 1);
  localparam logic [TW-1:0]  TIMER_INC = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0]  RETRY_INC = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [TAW:0]   TX_INC    = {{TAW{1'b0}}, 1'b1};
  localparam logic [RAW:0]   RX_INC    = {{RAW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, BACKOFF = 2'd2, GAP = 2'd3} state_t;

  // ---------------- outbound FIFO ----------------
  logic [28:0]  tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wr_ptr, tx_rd_ptr;
  logic         tx_empty, tx_full, tx_push, tx_pop;
  // Registered copy of "not empty"; it is what adds the second cycle of
  // outbound latency and keeps the FSM off the FIFO's combinational compare.
  logic         tx_pending;

  assign tx_empty         = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full          = (tx_wr_ptr[TAW] != tx_rd_ptr[TAW]) &&
                            (tx_wr_ptr[TAW-1:0] == tx_rd_ptr[TAW-1:0]);
  assign Host_Tx_Ready    = !tx_full;
  assign tx_push          = Host_Tx_Valid && Host_Tx_Ready;
  assign Packet_From_Node = tx_mem[tx_rd_ptr[TAW-1:0]];

  // Outbound storage; cleared on reset so the head reads 0 afterwards.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      for (int i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
    end else if (tx_push) begin
      tx_mem[tx_wr_ptr[TAW-1:0]] <= {Host_Tx_Addr, Host_Tx_Flag, Host_Tx_Data};
    end
  end

  // Outbound pointers and the delayed non-empty flag.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_pending <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_INC;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_INC;
      tx_pending <= !tx_empty;
    end
  end

  // ---------------- outbound FSM ----------------
  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic          drop;

  // State, timer and retry registers.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      state <= IDLE;
      timer <= '0;
      retry <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      retry <= retry_nxt;
    end
  end

  // Next-state: ack beats timeout; the head is popped only on ack or final drop.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = retry;
    tx_pop    = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (tx_pending) begin
          state_nxt = OFFER;
          timer_nxt = '0;
          retry_nxt = '0;
        end
      end
      OFFER: begin
        if (Core_Load_Ack) begin
          tx_pop    = 1'b1;
          state_nxt = GAP;
        end else if (timer == ACK_LAST) begin
          timer_nxt = '0;
          if (retry < RETRY_MAX) begin
            retry_nxt = retry + RETRY_INC;
            state_nxt = BACKOFF;
          end else begin
            tx_pop    = 1'b1;
            drop      = 1'b1;
            state_nxt = GAP;
          end
        end else begin
          timer_nxt = timer + TIMER_INC;
        end
      end
      BACKOFF: begin
        if (timer == BO_LAST) begin
          timer_nxt = '0;
          state_nxt = OFFER;
        end else begin
          timer_nxt = timer + TIMER_INC;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Packet_From_Node_Valid = (state == OFFER);
  assign dbg_state              = state;

  // Drop pulse and saturating drop counter.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      Tx_Drop       <= 1'b0;
      Tx_Fail_Count <= '0;
    end else begin
      Tx_Drop <= drop;
      if (drop && (Tx_Fail_Count != 8'hFF)) Tx_Fail_Count <= Tx_Fail_Count + 8'd1;
    end
  end

  // ---------------- inbound FIFO (first-word-fall-through) ----------------
  logic [23:0]  rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wr_ptr, rx_rd_ptr;
  logic         rx_empty, rx_full, rx_push, rx_pop;

  assign rx_empty      = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full       = (rx_wr_ptr[RAW] != rx_rd_ptr[RAW]) &&
                         (rx_wr_ptr[RAW-1:0] == rx_rd_ptr[RAW-1:0]);
  assign Host_Rx_Valid = !rx_empty;
  assign Host_Rx_Data  = rx_mem[rx_rd_ptr[RAW-1:0]];
  assign rx_pop        = Host_Rx_Valid && Host_Rx_Ready;
  // A full FIFO still takes a beat when the host frees a slot on the same edge.
  assign rx_push       = Packet_To_Node_Valid && (!rx_full || rx_pop);

  // Inbound storage; cleared on reset so the head reads 0 afterwards.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      for (int i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
    end else if (rx_push) begin
      rx_mem[rx_wr_ptr[RAW-1:0]] <= Packet_To_Node;
    end
  end

  // Inbound pointers and sticky overflow flag.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      Rx_Overflow <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_INC;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_INC;
      if (Packet_To_Node_Valid && !rx_push) Rx_Overflow <= 1'b1;
    end
  end

endmodule
